// File: rtl/imem_boot_fetch_ctrl.sv
// Boot/fetch sequencer for a single-port instruction RAM: zero-fill, stream-load
// a program image, then serve byte-addressed fetches with one-cycle latency.
module imem_boot_fetch_ctrl #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned ADDR_W   = 6,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  input  logic              reload,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [31:0]       fetch_instr,
  output logic              fetch_err,
  output logic              boot_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_LOAD,
    ST_RUN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [ADDR_W-1:0] ld_ptr_q, ld_ptr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       instr_hold_q;
  logic [31:0]       rsp_instr;
  logic [29:0]       fetch_word;
  logic              fetch_legal;

  assign fetch_word  = fetch_addr[31:2];
  assign fetch_legal = (fetch_addr[1:0] == 2'b00) && ({2'b00, fetch_word} < DEPTH);

  always_comb begin
    // NOTE: every output and next-state signal gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    ld_ptr_d    = ld_ptr_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    ld_ready    = 1'b0;
    fetch_ready = 1'b0;
    boot_done   = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    unique case (state_q)
      ST_CLEAR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = clr_ptr_q;
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == LAST_ADDR) begin
          clr_ptr_d = '0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = ld_ptr_q;
          mem_wdata = ld_data;
          ld_ptr_d  = ld_ptr_q + ADDR_W'(1);
          // The image ends on ld_last or when the array is full, whichever first.
          if (ld_last || (ld_ptr_q == LAST_ADDR)) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        boot_done   = 1'b1;
        fetch_ready = 1'b1;
        if (fetch_req) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = !fetch_legal;
          if (fetch_legal) begin
            mem_en   = 1'b1;
            mem_addr = fetch_addr[ADDR_W+1:2];
          end
        end
        // A fetch accepted alongside reload still answers in the first LOAD cycle.
        if (reload) begin
          state_d  = ST_LOAD;
          ld_ptr_d = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase

    // NOTE: reset is synchronous, so the outputs are forced quiet combinationally while it is held.
    if (!reset) begin
      ld_ready    = 1'b0;
      fetch_ready = 1'b0;
      boot_done   = 1'b0;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
    end
  end

  assign rsp_instr   = rsp_err_q ? NOP_WORD : mem_rdata;
  assign fetch_valid = reset && rsp_valid_q;
  assign fetch_err   = reset && rsp_valid_q && rsp_err_q;
  assign fetch_instr = !reset     ? 32'h0 :
                       rsp_valid_q ? rsp_instr : instr_hold_q;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!reset) begin
      state_q      <= ST_CLEAR;
      clr_ptr_q    <= '0;
      ld_ptr_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      instr_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      ld_ptr_q    <= ld_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      if (rsp_valid_q) instr_hold_q <= rsp_instr;
    end
  end

endmodule

// File: tb/tb_imem_boot_fetch_ctrl.sv
// Directed bench for imem_boot_fetch_ctrl with a behavioural synchronous-read RAM.
module tb_imem_boot_fetch_ctrl;

  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              ld_valid;
  logic              ld_ready;
  logic [31:0]       ld_data;
  logic              ld_last;
  logic              reload;
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [31:0]       fetch_instr;
  logic              fetch_err;
  logic              boot_done;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = 32'h0;

  logic [31:0] ram [64];
  logic [31:0] img [4] = '{32'h0000_0013, 32'h0198_0633, 32'h4034_0233, 32'h0094_8663};

  int n_cmp = 0;
  int n_mis = 0;

  imem_boot_fetch_ctrl #(.DEPTH(64), .ADDR_W(ADDR_W), .NOP_WORD(32'h0000_0013)) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .reload(reload),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_err(fetch_err),
    .boot_done(boot_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [76:0] got;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = {ld_ready, fetch_ready, fetch_valid, fetch_err, boot_done, mem_en, mem_we,
             mem_addr, mem_wdata, fetch_instr};
      n_cmp++;
      if (got !== '0) begin
        n_mis++;
        $display("FAIL reset_outputs[%0d]: got %h want 0", i, got);
      end
      tick();
    end
    reset = 1'b1;
  endtask

  task automatic test_clear();
    logic [40:0] got, exp;
    int bad_ram;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      got = {mem_en, mem_we, ld_ready, boot_done, fetch_ready, mem_addr, mem_wdata};
      exp = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'(i), 32'h0};
      n_cmp++;
      if (got !== exp) begin
        n_mis++;
        $display("FAIL clear_write[%0d]: got %h want %h", i, got, exp);
      end
      tick();
    end
    @(negedge clk);
    n_cmp++;
    if ({ld_ready, mem_en, mem_we, boot_done} !== 4'b1000) begin
      n_mis++;
      $display("FAIL clear_to_load: got %b want 1000", {ld_ready, mem_en, mem_we, boot_done});
    end
    bad_ram = 0;
    for (int a = 0; a < 64; a++) if (ram[a] !== 32'h0) bad_ram++;
    n_cmp++;
    if (bad_ram != 0) begin
      n_mis++;
      $display("FAIL clear_ram_zero: got %0d nonzero words want 0", bad_ram);
    end
  endtask

  task automatic test_load();
    for (int k = 0; k < 4; k++) begin
      ld_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({ld_ready, mem_en, boot_done} !== 3'b100) begin
        n_mis++;
        $display("FAIL load_gap[%0d]: got %b want 100", k, {ld_ready, mem_en, boot_done});
      end
      tick();
      ld_valid = 1'b1;
      ld_data  = img[k];
      ld_last  = (k == 3);
      @(negedge clk);
      n_cmp++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 6'(k), img[k]}) begin
        n_mis++;
        $display("FAIL load_write[%0d]: got addr %0d data %h want addr %0d data %h",
                 k, mem_addr, mem_wdata, k, img[k]);
      end
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({boot_done, fetch_ready, ld_ready} !== 3'b110) begin
      n_mis++;
      $display("FAIL load_to_run: got %b want 110", {boot_done, fetch_ready, ld_ready});
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (ram[k] !== img[k]) begin
        n_mis++;
        $display("FAIL load_ram[%0d]: got %h want %h", k, ram[k], img[k]);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 5; k++) begin
      fetch_req  = (k < 4);
      fetch_addr = 32'(4 * k);
      @(negedge clk);
      if (k < 4) begin
        n_cmp++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 6'(k)}) begin
          n_mis++;
          $display("FAIL b2b_read[%0d]: got en %b we %b addr %0d want 1 0 %0d",
                   k, mem_en, mem_we, mem_addr, k);
        end
      end
      n_cmp++;
      if (k == 0) begin
        if (fetch_valid !== 1'b0) begin
          n_mis++;
          $display("FAIL b2b_idle: got valid %b want 0", fetch_valid);
        end
      end else if ({fetch_valid, fetch_err, fetch_instr} !== {1'b1, 1'b0, img[k-1]}) begin
        n_mis++;
        $display("FAIL b2b_rsp[%0d]: got v %b e %b instr %h want 1 0 %h",
                 k - 1, fetch_valid, fetch_err, fetch_instr, img[k-1]);
      end
      tick();
    end
    @(negedge clk);
    n_cmp++;
    if ({fetch_valid, fetch_instr} !== {1'b0, img[3]}) begin
      n_mis++;
      $display("FAIL b2b_hold: got v %b instr %h want 0 %h", fetch_valid, fetch_instr, img[3]);
    end
    tick();
  endtask

  task automatic test_bad_fetch();
    logic [31:0] addrs [4] = '{32'h0000_0006, 32'h0000_0100, 32'h0000_00FC, 32'h4000_00FC};
    logic        errs  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] want;
    for (int k = 0; k < 4; k++) begin
      fetch_req  = 1'b1;
      fetch_addr = addrs[k];
      @(negedge clk);
      n_cmp++;
      if (mem_en !== !errs[k] || mem_we !== 1'b0) begin
        n_mis++;
        $display("FAIL bad_fetch_access[%h]: got en %b we %b want %b 0",
                 addrs[k], mem_en, mem_we, !errs[k]);
      end
      tick();
      fetch_req = 1'b0;
      want = errs[k] ? 32'h0000_0013 : 32'h0;
      @(negedge clk);
      n_cmp++;
      if ({fetch_valid, fetch_err, fetch_instr} !== {1'b1, errs[k], want}) begin
        n_mis++;
        $display("FAIL bad_fetch_rsp[%h]: got v %b e %b instr %h want 1 %b %h",
                 addrs[k], fetch_valid, fetch_err, fetch_instr, errs[k], want);
      end
      tick();
    end
  endtask

  task automatic test_reload_fetch();
    reload     = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 32'h8;
    @(negedge clk);
    n_cmp++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 6'd2}) begin
      n_mis++;
      $display("FAIL reload_fetch_read: got en %b we %b addr %0d want 1 0 2", mem_en, mem_we, mem_addr);
    end
    tick();
    reload    = 1'b0;
    fetch_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({fetch_valid, fetch_err, fetch_instr, boot_done, ld_ready} !== {1'b1, 1'b0, 32'h4034_0233, 1'b0, 1'b1}) begin
      n_mis++;
      $display("FAIL reload_fetch_rsp: got v %b e %b instr %h done %b rdy %b want 1 0 40340233 0 1",
               fetch_valid, fetch_err, fetch_instr, boot_done, ld_ready);
    end
    tick();
    ld_valid = 1'b1;
    ld_data  = 32'hDEAD_BEEF;
    ld_last  = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 6'd0, 32'hDEAD_BEEF}) begin
      n_mis++;
      $display("FAIL reload_first_write: got addr %0d data %h want 0 deadbeef", mem_addr, mem_wdata);
    end
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (boot_done !== 1'b1) begin
      n_mis++;
      $display("FAIL reload_last_run: got boot_done %b want 1", boot_done);
    end
    tick();
  endtask

  task automatic test_overflow();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    for (int i = 0; i < 70; i++) begin
      ld_valid = 1'b1;
      ld_last  = 1'b0;
      ld_data  = 32'hA000_0000 + 32'(i);
      @(negedge clk);
      n_cmp++;
      if (i < 64) begin
        if ({ld_ready, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 6'(i), ld_data}) begin
          n_mis++;
          $display("FAIL overflow_accept[%0d]: got rdy %b en %b we %b addr %0d data %h",
                   i, ld_ready, mem_en, mem_we, mem_addr, mem_wdata);
        end
      end else if ({ld_ready, mem_we, boot_done} !== 3'b001) begin
        n_mis++;
        $display("FAIL overflow_reject[%0d]: got rdy %b we %b done %b want 0 0 1",
                 i, ld_ready, mem_we, boot_done);
      end
      tick();
    end
    ld_valid = 1'b0;
    n_cmp++;
    if (ram[0] !== 32'hA000_0000 || ram[63] !== 32'hA000_003F) begin
      n_mis++;
      $display("FAIL overflow_ram: got %h %h want a0000000 a000003f", ram[0], ram[63]);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [76:0] got;
    reload = 1'b1;
    tick();
    reload     = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    @(negedge clk);
    n_cmp++;
    if ({mem_en, fetch_ready, ld_ready} !== 3'b001) begin
      n_mis++;
      $display("FAIL load_fetch_ignored: got en %b frdy %b lrdy %b want 0 0 1", mem_en, fetch_ready, ld_ready);
    end
    tick();
    fetch_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (fetch_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL load_fetch_no_rsp: got valid %b want 0", fetch_valid);
    end
    tick();
    ld_valid = 1'b1;
    ld_data  = 32'h1234_5678;
    @(negedge clk);
    n_cmp++;
    if ({mem_we, mem_addr} !== {1'b1, 6'd0}) begin
      n_mis++;
      $display("FAIL mid_load_write: got we %b addr %0d want 1 0", mem_we, mem_addr);
    end
    tick();
    reset     = 1'b0;
    fetch_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      got = {ld_ready, fetch_ready, fetch_valid, fetch_err, boot_done, mem_en, mem_we,
             mem_addr, mem_wdata, fetch_instr};
      n_cmp++;
      if (got !== '0) begin
        n_mis++;
        $display("FAIL mid_load_reset[%0d]: got %h want 0", i, got);
      end
      tick();
    end
    reset     = 1'b1;
    ld_valid  = 1'b0;
    fetch_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({mem_en, mem_we, ld_ready, mem_addr, mem_wdata} !== {3'b110, 6'(i), 32'h0}) begin
        n_mis++;
        $display("FAIL restart_clear[%0d]: got en %b we %b rdy %b addr %0d want 1 1 0 %0d",
                 i, mem_en, mem_we, ld_ready, mem_addr, i);
      end
      tick();
    end
  endtask

  initial begin
    reset      = 1'b0;
    ld_valid   = 1'b0;
    ld_data    = 32'h0;
    ld_last    = 1'b0;
    reload     = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = 32'h0;
    tick();
    test_reset();
    test_clear();
    test_load();
    test_back_to_back();
    test_bad_fetch();
    test_reload_fetch();
    test_overflow();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
